// File: rtl/open_list_queue.sv
// rtl/open_list_queue.sv - sorted open-list store for the A* datapath
//
// Keeps up to DEPTH (f-cost, node id) pairs in ascending cost order using a
// shift-register insertion array. Upstream inserts one pair per cycle; the
// search controller pops the lowest-cost pair from slot 0.
//
// Ports:
//   Clk        system clock, all state on the rising edge
//   Reset      synchronous active-high reset
//   Clear      synchronous flush of all entries (Reset has priority)
//   Ins_Valid  insert request
//   Ins_Ready  insert accepted when high (!Full)
//   Ins_Cost   f-cost of the node to insert (unsigned)
//   Ins_Id     node id to insert
//   Pop_Req    consume head entry
//   Pop_Valid  head entry valid (!Empty)
//   Pop_Cost   head f-cost, straight from the slot 0 register
//   Pop_Id     head node id, straight from the slot 0 register
//   Count      number of valid entries
//   Full       Count == DEPTH
//   Empty      Count == 0
//   Overflow   sticky, set by an insert attempted while Full

module open_list_queue #(
  parameter int DEPTH = 8,
  parameter int KEY_W = 8,
  parameter int ID_W  = 6,
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Clear,
  input  logic             Ins_Valid,
  output logic             Ins_Ready,
  input  logic [KEY_W-1:0] Ins_Cost,
  input  logic [ID_W-1:0]  Ins_Id,
  input  logic             Pop_Req,
  output logic             Pop_Valid,
  output logic [KEY_W-1:0] Pop_Cost,
  output logic [ID_W-1:0]  Pop_Id,
  output logic [CNT_W-1:0] Count,
  output logic             Full,
  output logic             Empty,
  output logic             Overflow
);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

  // Slot storage
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [KEY_W-1:0] cost_q [DEPTH];
  logic [KEY_W-1:0] cost_d [DEPTH];
  logic [ID_W-1:0]  id_q   [DEPTH];
  logic [ID_W-1:0]  id_d   [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  // Decoded status, all from registered state only
  logic full_w, empty_w;
  logic ins_fire, pop_fire, ins_drop;

  assign full_w   = (count_q == DEPTH_CNT);
  assign empty_w  = (count_q == '0);
  assign ins_fire = Ins_Valid && !full_w;
  assign pop_fire = Pop_Req && !empty_w;
  assign ins_drop = Ins_Valid && full_w;

  // Slot array padded on both sides so every slot can name its left
  // neighbour (index i), itself (i+1) and its right neighbour (i+2) without
  // out-of-range selects. The right pad is an invalid copy of the last slot,
  // which is what shifts into slot DEPTH-1 on a pop.
  logic [DEPTH+1:0] ext_valid;
  logic [KEY_W-1:0] ext_cost [DEPTH+2];
  logic [ID_W-1:0]  ext_id   [DEPTH+2];

  always_comb begin
    ext_valid   = '0;
    ext_cost[0] = '0;
    ext_id[0]   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ext_valid[i+1] = valid_q[i];
      ext_cost[i+1]  = cost_q[i];
      ext_id[i+1]    = id_q[i];
    end
    ext_cost[DEPTH+1] = cost_q[DEPTH-1];
    ext_id[DEPTH+1]   = id_q[DEPTH-1];
  end

  // bef[i]: the new entry belongs in front of slot i (slot empty or holds a
  // strictly greater cost). Because the array is contiguous and sorted this
  // vector is a thermometer code; the insertion point is its lowest set bit.
  // Strict '>' keeps equal costs in arrival order.
  logic [DEPTH:0]   bef;
  logic [DEPTH-1:0] bef_r;  // same test against the array after a pop
  logic [DEPTH-1:0] pt;     // one-hot insertion slot, insert only
  logic [DEPTH-1:0] pt_r;   // one-hot insertion slot, insert with pop

  always_comb begin
    bef = '0;
    for (int i = 0; i < DEPTH; i++) begin
      bef[i] = !valid_q[i] || (cost_q[i] > Ins_Cost);
    end
    bef[DEPTH] = 1'b1;
  end

  // After a pop, slot i sees what was in slot i+1, so the comparisons simply
  // move down one position.
  assign bef_r = bef[DEPTH:1];
  assign pt    = bef[DEPTH-1:0] & ~{bef[DEPTH-2:0], 1'b0};
  assign pt_r  = bef_r & ~{bef_r[DEPTH-2:0], 1'b0};

  // Per-slot next state: each slot picks new entry / left / self / right
  // based only on its own and its neighbour's comparison.
  always_comb begin
    valid_d    = valid_q;
    cost_d     = cost_q;
    id_d       = id_q;
    count_d    = count_q;
    overflow_d = overflow_q | ins_drop;

    if (Clear) begin
      valid_d    = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        cost_d[i] = '0;
        id_d[i]   = '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ins_fire && !pop_fire) begin
          if (pt[i]) begin
            valid_d[i] = 1'b1;
            cost_d[i]  = Ins_Cost;
            id_d[i]    = Ins_Id;
          end else if (bef[i]) begin
            // behind the insertion point: make room by shifting right
            valid_d[i] = ext_valid[i];
            cost_d[i]  = ext_cost[i];
            id_d[i]    = ext_id[i];
          end
        end else if (ins_fire && pop_fire) begin
          if (pt_r[i]) begin
            valid_d[i] = 1'b1;
            cost_d[i]  = Ins_Cost;
            id_d[i]    = Ins_Id;
          end else if (bef_r[i]) begin
            // the pop and the insert shifts cancel: slot keeps its value
            valid_d[i] = ext_valid[i+1];
            cost_d[i]  = ext_cost[i+1];
            id_d[i]    = ext_id[i+1];
          end else begin
            valid_d[i] = ext_valid[i+2];
            cost_d[i]  = ext_cost[i+2];
            id_d[i]    = ext_id[i+2];
          end
        end else if (pop_fire) begin
          valid_d[i] = ext_valid[i+2];
          cost_d[i]  = ext_cost[i+2];
          id_d[i]    = ext_id[i+2];
        end
      end

      case ({ins_fire, pop_fire})
        2'b10:   count_d = count_q + ONE_CNT;
        2'b01:   count_d = count_q - ONE_CNT;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        cost_q[i] <= '0;
        id_q[i]   <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < DEPTH; i++) begin
        cost_q[i] <= cost_d[i];
        id_q[i]   <= id_d[i];
      end
    end
  end

  assign Count     = count_q;
  assign Full      = full_w;
  assign Empty     = empty_w;
  assign Ins_Ready = !full_w;
  assign Pop_Valid = !empty_w;
  assign Pop_Cost  = cost_q[0];
  assign Pop_Id    = id_q[0];
  assign Overflow  = overflow_q;

endmodule

// File: tb/tb_open_list_queue.sv
// tb/tb_open_list_queue.sv - self-checking bench for open_list_queue

module tb_open_list_queue;

  logic       Clk = 1'b0;
  logic       Reset, Clear, Ins_Valid, Pop_Req;
  logic       Ins_Ready, Pop_Valid, Full, Empty, Overflow;
  logic [7:0] Ins_Cost, Pop_Cost;
  logic [5:0] Ins_Id, Pop_Id;
  logic [3:0] Count;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  open_list_queue #(.DEPTH(8), .KEY_W(8), .ID_W(6), .CNT_W(4)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Clear     (Clear),
    .Ins_Valid (Ins_Valid),
    .Ins_Ready (Ins_Ready),
    .Ins_Cost  (Ins_Cost),
    .Ins_Id    (Ins_Id),
    .Pop_Req   (Pop_Req),
    .Pop_Valid (Pop_Valid),
    .Pop_Cost  (Pop_Cost),
    .Pop_Id    (Pop_Id),
    .Count     (Count),
    .Full      (Full),
    .Empty     (Empty),
    .Overflow  (Overflow)
  );

  typedef struct {
    bit rst;
    bit clr;
    bit iv;
    int cost;
    int id;
    bit pr;
    int e_cnt;
    bit chk_head;
    int e_cost;
    int e_id;
    bit e_ovf;
  } vec_t;

  vec_t vecs[$];

  typedef struct {
    int c;
    int id;
  } ent_t;

  ent_t mq[$];
  bit   m_ovf;
  bit   m_zero;

  task automatic add(input bit rst, input bit clr, input bit iv, input int cost,
                     input int id, input bit pr, input int e_cnt, input bit chk_head,
                     input int e_cost, input int e_id, input bit e_ovf);
    vec_t v;
    v.rst = rst; v.clr = clr; v.iv = iv; v.cost = cost; v.id = id; v.pr = pr;
    v.e_cnt = e_cnt; v.chk_head = chk_head; v.e_cost = e_cost; v.e_id = e_id;
    v.e_ovf = e_ovf;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit clr, input bit iv, input int cost,
                       input int id, input bit pr);
    Reset     = rst;
    Clear     = clr;
    Ins_Valid = iv;
    Ins_Cost  = 8'(cost);
    Ins_Id    = 6'(id);
    Pop_Req   = pr;
    @(posedge Clk);
    #1;
  endtask

  task automatic check_status(input string tag, input int e_cnt, input bit e_ovf);
    check({tag, "_count"},     32'(Count),     32'(e_cnt));
    check({tag, "_empty"},     32'(Empty),     32'(e_cnt == 0));
    check({tag, "_full"},      32'(Full),      32'(e_cnt == 8));
    check({tag, "_ins_ready"}, 32'(Ins_Ready), 32'(e_cnt != 8));
    check({tag, "_pop_valid"}, 32'(Pop_Valid), 32'(e_cnt != 0));
    check({tag, "_overflow"},  32'(Overflow),  32'(e_ovf));
  endtask

  // Reference: a sorted list of pairs. Pop takes the front; an insert goes
  // in front of the first remaining entry with a strictly greater cost.
  task automatic model_step(input bit rst, input bit clr, input bit iv, input int cost,
                            input int id, input bit pr);
    bit   was_full, was_empty, do_ins, do_pop;
    int   pos;
    ent_t e;
    if (rst || clr) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_zero = 1'b1;
    end else begin
      was_full  = (mq.size() == 8);
      was_empty = (mq.size() == 0);
      do_ins    = iv && !was_full;
      do_pop    = pr && !was_empty;
      if (iv && was_full) m_ovf = 1'b1;
      if (do_pop) void'(mq.pop_front());
      if (do_ins) begin
        pos = mq.size();
        for (int k = 0; k < mq.size(); k++) begin
          if (mq[k].c > cost) begin
            pos = k;
            break;
          end
        end
        e.c  = cost;
        e.id = id;
        mq.insert(pos, e);
      end
      if (do_ins || do_pop) m_zero = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string tag;
    bit    r_rst, r_clr, r_iv, r_pr;
    int    r_cost, r_id;

    Reset = 1'b1; Clear = 1'b0; Ins_Valid = 1'b0; Pop_Req = 1'b0;
    Ins_Cost = '0; Ins_Id = '0;

    // reset held for five cycles
    for (int k = 0; k < 5; k++) add(1,0,0,0,0,0, 0,1,0,0,0);
    // sorted insert then drain
    add(0,0,1,40,1,0, 1,1,40,1,0);
    add(0,0,1,10,2,0, 2,1,10,2,0);
    add(0,0,1,30,3,0, 3,1,10,2,0);
    add(0,0,1,20,4,0, 4,1,10,2,0);
    add(0,0,0,0,0,1,  3,1,20,4,0);
    add(0,0,0,0,0,1,  2,1,30,3,0);
    add(0,0,0,0,0,1,  1,1,40,1,0);
    add(0,0,0,0,0,1,  0,0,0,0,0);
    // equal costs stay in arrival order
    add(0,0,1,25,7,0,  1,1,25,7,0);
    add(0,0,1,25,8,0,  2,1,25,7,0);
    add(0,0,1,25,9,0,  3,1,25,7,0);
    add(0,0,1,5,10,0,  4,1,5,10,0);
    add(0,0,0,0,0,1,   3,1,25,7,0);
    add(0,0,0,0,0,1,   2,1,25,8,0);
    add(0,0,0,0,0,1,   1,1,25,9,0);
    add(0,0,0,0,0,1,   0,0,0,0,0);
    // fill with descending costs, then overflow
    for (int k = 0; k < 8; k++) add(0,0,1,80-10*k,11+k,0, k+1,1,80-10*k,11+k,0);
    add(0,0,1,1,19,0,  8,1,10,18,1);
    add(0,0,0,0,0,1,   7,1,20,17,1);
    add(0,1,1,3,5,1,   0,1,0,0,0);
    // insert with pop, new entry lands at the head
    add(0,0,1,10,20,0, 1,1,10,20,0);
    add(0,0,1,30,21,0, 2,1,10,20,0);
    add(0,0,1,50,22,0, 3,1,10,20,0);
    add(0,0,1,20,23,1, 3,1,20,23,0);
    add(0,0,0,0,0,1,   2,1,30,21,0);
    add(0,0,0,0,0,1,   1,1,50,22,0);
    add(0,0,0,0,0,1,   0,0,0,0,0);
    // insert with pop, new entry lands at the tail
    add(0,0,1,10,24,0, 1,1,10,24,0);
    add(0,0,1,30,25,0, 2,1,10,24,0);
    add(0,0,1,50,26,0, 3,1,10,24,0);
    add(0,0,1,60,27,1, 3,1,30,25,0);
    add(0,0,0,0,0,1,   2,1,50,26,0);
    add(0,0,0,0,0,1,   1,1,60,27,0);
    add(0,0,0,0,0,1,   0,0,0,0,0);
    // insert with pop at Count == 1
    add(0,0,1,50,30,0, 1,1,50,30,0);
    add(0,0,1,70,31,1, 1,1,70,31,0);
    add(0,0,0,0,0,1,   0,0,0,0,0);
    // pop while empty, then Clear beats a concurrent insert
    add(0,0,0,0,0,1,   0,0,0,0,0);
    add(0,0,1,5,1,0,   1,1,5,1,0);
    add(0,0,1,6,2,0,   2,1,5,1,0);
    add(0,0,1,7,3,0,   3,1,5,1,0);
    add(0,1,1,1,5,0,   0,1,0,0,0);

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].clr, vecs[k].iv, vecs[k].cost, vecs[k].id, vecs[k].pr);
      tag = $sformatf("vec%0d", k);
      check_status(tag, vecs[k].e_cnt, vecs[k].e_ovf);
      if (vecs[k].chk_head) begin
        check({tag, "_pop_cost"}, 32'(Pop_Cost), 32'(vecs[k].e_cost));
        check({tag, "_pop_id"},   32'(Pop_Id),   32'(vecs[k].e_id));
      end
    end

    // randomized traffic against the list model
    model_step(1,0,0,0,0,0);
    drive(1,0,0,0,0,0);
    for (int n = 0; n < 3000; n++) begin
      r_rst  = ($urandom_range(0, 299) == 0);
      r_clr  = ($urandom_range(0, 99) == 0);
      if ((n % 400) < 200) begin
        r_iv = ($urandom_range(0, 9) < 8);
        r_pr = ($urandom_range(0, 9) < 3);
      end else begin
        r_iv = ($urandom_range(0, 9) < 3);
        r_pr = ($urandom_range(0, 9) < 8);
      end
      r_cost = $urandom_range(0, 15);
      r_id   = $urandom_range(0, 63);
      model_step(r_rst, r_clr, r_iv, r_cost, r_id, r_pr);
      drive(r_rst, r_clr, r_iv, r_cost, r_id, r_pr);
      tag = $sformatf("rnd%0d", n);
      check_status(tag, mq.size(), m_ovf);
      if (mq.size() > 0) begin
        check({tag, "_pop_cost"}, 32'(Pop_Cost), 32'(mq[0].c));
        check({tag, "_pop_id"},   32'(Pop_Id),   32'(mq[0].id));
      end else if (m_zero) begin
        check({tag, "_pop_cost"}, 32'(Pop_Cost), 32'd0);
        check({tag, "_pop_id"},   32'(Pop_Id),   32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
